// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing the register-file read port among 4 requesters.
// Ports: clk/reset, req_valid_i/req_addr_i/req_ready_o (request side),
// sel_o/rf_data_i (mux), wr_en_i/wr_addr_i/wr_data_i (bypass), stall_i,
// rsp_valid_o/rsp_data_o/rsp_ready_i (response side), grant_cnt_o (stats).
module rf_read_port_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_valid_i,
  input  logic [19:0]      req_addr_i,
  output logic [3:0]       req_ready_o,
  output logic [4:0]       sel_o,
  input  logic [N-1:0]     rf_data_i,
  input  logic             wr_en_i,
  input  logic [4:0]       wr_addr_i,
  input  logic [N-1:0]     wr_data_i,
  input  logic             stall_i,
  output logic [3:0]       rsp_valid_o,
  output logic [N-1:0]     rsp_data_o,
  input  logic             rsp_ready_i,
  output logic [CNT_W-1:0] grant_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  logic [1:0]   ptr;
  logic [1:0]   g;
  logic         found;
  logic         can_grant;
  logic         grant;
  logic [4:0]   last_addr;
  logic [4:0]   g_addr;
  logic [N-1:0] rd_data;
  logic [4:0]   addr_arr [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr_arr[k] = req_addr_i[5*k +: 5];
    end
  end

  // Search starts at ptr and wraps; first pending request wins.
  always_comb begin
    found = 1'b0;
    g     = ptr;
    for (int i = 0; i < 4; i++) begin
      if (!found && req_valid_i[ptr + 2'(i)]) begin
        found = 1'b1;
        g     = ptr + 2'(i);
      end
    end
  end

  // A held response consumed this cycle frees the slot for a new grant.
  assign can_grant = reset && !stall_i &&
                     (state == IDLE || rsp_ready_i);
  assign grant     = can_grant && found;

  assign req_ready_o = grant ? (4'b0001 << g) : 4'b0000;
  assign g_addr      = addr_arr[g];
  assign sel_o       = grant ? g_addr : last_addr;

  // r0 reads as zero and is never bypassed.
  always_comb begin
    if (g_addr == 5'd0) begin
      rd_data = '0;
    end else if (wr_en_i && wr_addr_i == g_addr) begin
      rd_data = wr_data_i;
    end else begin
      rd_data = rf_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      rsp_valid_o <= 4'b0000;
      rsp_data_o  <= '0;
      grant_cnt_o <= '0;
      last_addr   <= 5'd0;
    end else if (grant) begin
      state       <= HOLD;
      ptr         <= g + 2'd1;
      rsp_valid_o <= req_ready_o;
      rsp_data_o  <= rd_data;
      grant_cnt_o <= grant_cnt_o + CNT_W'(1);
      last_addr   <= g_addr;
    end else if (state == HOLD && rsp_ready_i) begin
      state       <= IDLE;
      rsp_valid_o <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Scoreboard bench for rf_read_port_arbiter: directed cases then random traffic.
// Stimulus process feeds a reference model; a monitor pops responses.
module tb_rf_read_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [19:0] req_addr = '0;
  logic [3:0]  req_ready;
  logic [4:0]  sel;
  logic [31:0] rf_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        stall = 1'b0;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b0;
  logic [15:0] grant_cnt;

  always #5 clk = ~clk;

  rf_read_port_arbiter #(.N(32), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_i(req_valid),
    .req_addr_i(req_addr),
    .req_ready_o(req_ready),
    .sel_o(sel),
    .rf_data_i(rf_data),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .stall_i(stall),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data),
    .rsp_ready_i(rsp_ready),
    .grant_cnt_o(grant_cnt)
  );

  // Behavioural register file feeding the mux input.
  logic [31:0] regs [32];
  assign rf_data = regs[sel];

  typedef struct {
    logic [3:0]  oh;
    logic [31:0] d;
    logic [15:0] c;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;

  int          mptr = 0;
  int          mcnt = 0;
  bit          mheld = 0;
  logic [4:0]  mlast = '0;
  int          last_g = -1;
  bit          held_now = 0;
  bit          check_en = 0;
  logic        pw_en = 1'b0;
  logic [4:0]  pw_a = '0;
  logic [31:0] pw_d = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [19:0] a,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic st,
                      input logic rr);
    int eg;
    logic [4:0] ea;
    logic [31:0] ed;
    logic [3:0] er;
    @(negedge clk);
    if (pw_en && pw_a != 5'd0) regs[pw_a] = pw_d;
    pw_en = we;
    pw_a = wa;
    pw_d = wd;
    req_valid = v;
    req_addr = a;
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    stall = st;
    rsp_ready = rr;
    #1;
    held_now = mheld;
    eg = -1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (mptr + i) % 4;
      if (eg < 0 && v[k]) eg = k;
    end
    er = 4'b0000;
    last_g = -1;
    if (!st && (!mheld || rr) && eg >= 0) begin
      exp_t e;
      er = 4'b0001 << eg;
      ea = a[5*eg +: 5];
      if (ea == 5'd0) ed = '0;
      else if (we && wa == ea) ed = wd;
      else ed = regs[ea];
      mcnt = (mcnt + 1) % 65536;
      e.oh = er;
      e.d = ed;
      e.c = 16'(mcnt);
      q.push_back(e);
      mptr = (eg + 1) % 4;
      mheld = 1;
      mlast = ea;
      last_g = eg;
    end else if (mheld && rr) begin
      mheld = 0;
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("sel", 64'(sel), 64'(mlast));
    check_en = 1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    reset = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_grant_cnt", 64'(grant_cnt), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_sel", 64'(sel), 64'(0));
    q.delete();
    mptr = 0;
    mheld = 0;
    mcnt = 0;
    mlast = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: checks the presented response and pops it when consumed.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && check_en) begin
        check_en = 0;
        chk("rsp_present", 64'(rsp_valid != 4'b0000), 64'(held_now));
        if (rsp_valid != 4'b0000) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
          end else begin
            chk("rsp", {12'd0, rsp_valid, rsp_data, grant_cnt},
                {12'd0, q[0].oh, q[0].d, q[0].c});
            if (rsp_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]  cv;
    logic [19:0] ca;
    logic [4:0]  wa;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hFFFF_FFFF;
    regs[5] = 32'hDEAD_BEEF;
    #2;
    chk("init_req_ready", 64'(req_ready), 64'(0));
    chk("init_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("init_grant_cnt", 64'(grant_cnt), 64'(0));
    chk("init_rsp_data", 64'(rsp_data), 64'(0));
    chk("init_sel", 64'(sel), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // single request
    step(4'b0001, 20'd5, 0, 0, 0, 0, 1);
    step(4'b0000, 20'd0, 0, 0, 0, 0, 1);
    chk("single_cnt", 64'(grant_cnt), 64'(1));

    // round-robin from requester 0
    async_reset();
    repeat (5) step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 0, 1);
    step(4'b0000, 20'd0, 0, 0, 0, 0, 1);
    chk("rr_cnt", 64'(grant_cnt), 64'(5));

    // backpressure then same-cycle regrant
    step(4'b0001, 20'd9, 0, 0, 0, 0, 1);
    repeat (3) step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 0, 0);
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 0, 1);
    step(4'b0000, 20'd0, 0, 0, 0, 0, 1);

    // bypass and r0
    regs[7] = 32'h0;
    step(4'b0001, 20'd7, 1, 5'd7, 32'h1234_5678, 0, 1);
    step(4'b0001, 20'd0, 1, 5'd0, 32'hABCD_0123, 0, 1);
    step(4'b0000, 20'd0, 1, 5'd3, 32'h5555_AAAA, 0, 0);
    step(4'b0000, 20'd0, 0, 0, 0, 0, 1);

    // stall blocks grants but drains
    step(4'b0010, 20'd31 << 5, 0, 0, 0, 0, 1);
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 1, 0);
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 1, 1);
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 1, 1);
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 0, 1);

    // randomized traffic
    cv = '0;
    ca = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (cv[k] && last_g != k && $urandom_range(0, 7) != 0) begin
          cv[k] = 1'b1;
        end else begin
          cv[k] = 1'($urandom_range(0, 1));
          ca[5*k +: 5] = 5'($urandom_range(0, 31));
        end
      end
      if ($urandom_range(0, 2) == 0) wa = ca[5*$urandom_range(0, 3) +: 5];
      else wa = 5'($urandom_range(0, 31));
      step(cv, ca, 1'($urandom_range(0, 1)), wa, $urandom,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end

    // reset while holding, then first grant goes to requester 0
    step(4'b0100, 20'd6 << 10, 0, 0, 0, 0, 1);
    async_reset();
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 0, 0, 0, 1);

    repeat (4) step(4'b0000, 20'd0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    chk("drain_empty", 64'(q.size()), 64'(0));
    chk("final_cnt", 64'(grant_cnt), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
